// File: rtl/sync_pkg.sv
// Shared constants for the multi-channel toggle req/ack receiver.
// Optional feature macro used by the channel logic: SYNC_RX_CHANGE_ONLY_EN.
package sync_pkg;

  // Per-channel FSM state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  // Legal synchroniser depth range and settle counter width.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int SETTLE_W        = 4;

  // Settle counter load value, truncated to the counter width.
  function automatic logic [SETTLE_W-1:0] settle_load(input int cyc);
    return SETTLE_W'(cyc);
  endfunction

endpackage

// File: rtl/sync_rx_chan.sv
// One receive channel: req_tog synchroniser, edge detect, IDLE/SETTLE/PRESENT/ACK
// FSM, settle counter, captured data, sticky overrun flag.
// With SYNC_RX_CHANGE_ONLY_EN defined, a request whose data equals the last
// accepted value is acknowledged without being presented.
//
// Handshake: out_data is transferred on any clock edge where out_valid and
// out_ready are both high; out_valid never drops and out_data never changes
// while out_valid is high and out_ready is low.
module sync_rx_chan
  import sync_pkg::*;
#(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_tog,
  input  logic [W-1:0] data_in,
  input  logic         out_ready,
  input  logic         ovr_clr,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         ack_tog,
  output logic         ovr_flag
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [1:0]             state_q, state_d;
  logic [SETTLE_W-1:0]    cnt_q, cnt_d;
  logic [SETTLE_W-1:0]    cnt_dec;
  logic [W-1:0]           out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   ack_q, ack_d;
  logic                   ovr_q, ovr_d;
  logic                   req_edge;
  logic                   capture_now;
  logic                   is_repeat;

  assign req_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign cnt_dec  = cnt_q - SETTLE_W'(1);

  // Data is sampled either straight from IDLE (no settle time) or when the
  // settle counter is about to reach zero.
  assign capture_now = ((state_q == ST_IDLE) && req_edge && (SETTLE_CYC == 0)) ||
                       ((state_q == ST_SETTLE) && (cnt_dec == '0));

`ifdef SYNC_RX_CHANGE_ONLY_EN
  logic [W-1:0] last_data_q, last_data_d;

  assign is_repeat = (data_in == last_data_q);

  // Remember the most recently accepted value.
  always_comb begin
    last_data_d = last_data_q;
    if ((state_q == ST_PRESENT) && out_valid_q && out_ready) last_data_d = out_data_q;
  end

  // last_data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_data_q <= '0;
    else        last_data_q <= last_data_d;
  end
`else
  assign is_repeat = 1'b0;
`endif

  // State register plus all channel flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
      ovr_q       <= ovr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          if (capture_now) state_d = is_repeat ? ST_ACK : ST_PRESENT;
          else             state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (capture_now) state_d = is_repeat ? ST_ACK : ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_valid_q && out_ready) state_d = ST_ACK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic: synchroniser shift, counter, capture, ack, overrun.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], req_tog};
    prev_d      = sync_q[SYNC_STAGES-1];
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ack_d       = ack_q;
    ovr_d       = ovr_clr ? 1'b0 : ovr_q;
    if ((state_q == ST_IDLE) && req_edge) cnt_d = settle_load(SETTLE_CYC);
    if (state_q == ST_SETTLE)             cnt_d = cnt_dec;
    if (capture_now && !is_repeat) begin
      out_data_d  = data_in;
      out_valid_d = 1'b1;
    end
    if ((state_q == ST_PRESENT) && out_valid_q && out_ready) out_valid_d = 1'b0;
    if (state_q == ST_ACK) ack_d = ~ack_q;
    // A new request while busy is dropped; only the sticky flag records it.
    if (req_edge && (state_q != ST_IDLE)) ovr_d = 1'b1;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ack_tog   = ack_q;
  assign ovr_flag  = ovr_q;

endmodule

// File: rtl/sync_rx_mc.sv
// Multi-channel toggle req/ack receiver, destination clock domain only.
// Optional feature macro: SYNC_RX_CHANGE_ONLY_EN (see sync_rx_chan).
// Channel i uses bit i of each per-channel bus and bits [i*W +: W] of data buses.
module sync_rx_mc #(
  parameter int W           = 32,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req_tog,
  input  logic [N_CH*W-1:0] data_in,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [N_CH-1:0]   ack_tog,
  output logic [N_CH-1:0]   ovr_flag,
  input  logic              ovr_clr
);

  // One independent channel per bus slice; ovr_clr is shared.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sync_rx_chan #(
      .W          (W),
      .SYNC_STAGES(SYNC_STAGES),
      .SETTLE_CYC (SETTLE_CYC)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_tog  (req_tog[i]),
      .data_in  (data_in[i*W +: W]),
      .out_ready(out_ready[i]),
      .ovr_clr  (ovr_clr),
      .out_data (out_data[i*W +: W]),
      .out_valid(out_valid[i]),
      .ack_tog  (ack_tog[i]),
      .ovr_flag (ovr_flag[i])
    );
  end

endmodule

// File: tb/tb_sync_rx_mc.sv
// Bench for sync_rx_mc with default parameters (W=32, N_CH=4, 2 sync stages,
// 1 settle cycle). The change-only scenario runs when SYNC_RX_CHANGE_ONLY_EN
// is defined for the build.
module tb_sync_rx_mc;

  localparam int W    = 32;
  localparam int N_CH = 4;

  logic              clk;
  logic              rst_n;
  logic [N_CH-1:0]   req_tog;
  logic [N_CH*W-1:0] data_in;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_valid;
  logic [N_CH-1:0]   out_ready;
  logic [N_CH-1:0]   ack_tog;
  logic [N_CH-1:0]   ovr_flag;
  logic              ovr_clr;

  int              n_checks;
  int              n_pass;
  logic [N_CH-1:0] exp_ack;
  logic [W-1:0]    exp_q[$];
  int              exp_ch_q[$];

  sync_rx_mc #(.W(W), .N_CH(N_CH), .SYNC_STAGES(2), .SETTLE_CYC(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_tog  (req_tog),
    .data_in  (data_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ack_tog  (ack_tog),
    .ovr_flag (ovr_flag),
    .ovr_clr  (ovr_clr)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sender driver: present data and flip the request toggle.
  task automatic send(input int ch, input logic [W-1:0] d);
    data_in[ch*W +: W] = d;
    req_tog[ch] = ~req_tog[ch];
  endtask

  task automatic push_exp(input int ch, input logic [W-1:0] d);
    exp_q.push_back(d);
    exp_ch_q.push_back(ch);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_tog = '0; data_in = '0; out_ready = '0; ovr_clr = 1'b0;
    exp_ack = '0;
    repeat (3) tick();
    n_checks++; if (out_valid !== '0) $display("FAIL rst_valid: got %h want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (ack_tog !== '0) $display("FAIL rst_ack: got %h want 0", ack_tog); else n_pass++;
    n_checks++; if (ovr_flag !== '0) $display("FAIL rst_ovr: got %h want 0", ovr_flag); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    int ch;
    out_ready = '1;
    send(0, 32'hDEAD_BEEF);
    push_exp(0, 32'hDEAD_BEEF);
    repeat (3) tick();
    n_checks++; if (out_valid[0] !== 1'b0) $display("FAIL t1_early: valid got %b want 0 at edge 3", out_valid[0]); else n_pass++;
    tick();
    n_checks++; if (out_valid[0] !== 1'b1) $display("FAIL t1_valid: got %b want 1 at edge 4", out_valid[0]); else n_pass++;
    d = exp_q.pop_front(); ch = exp_ch_q.pop_front();
    n_checks++; if (out_data[ch*W +: W] !== d) $display("FAIL t1_data: got %h want %h", out_data[ch*W +: W], d); else n_pass++;
    tick();
    n_checks++; if (out_valid[0] !== 1'b0) $display("FAIL t1_one_cycle: valid got %b want 0", out_valid[0]); else n_pass++;
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t1_ack_hold: got %b want %b", ack_tog, exp_ack); else n_pass++;
    exp_ack[0] = ~exp_ack[0];
    tick();
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t1_ack: got %b want %b", ack_tog, exp_ack); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    logic [W-1:0] e;
    int ch;
    logic stable;
    out_ready[0] = 1'b0;
    d = W'($urandom);
    send(0, d);
    push_exp(0, d);
    repeat (4) tick();
    e = exp_q.pop_front(); ch = exp_ch_q.pop_front();
    n_checks++; if (out_valid[ch] !== 1'b1 || out_data[ch*W +: W] !== e)
      $display("FAIL t2_present: valid %b data %h want 1 %h", out_valid[ch], out_data[ch*W +: W], e); else n_pass++;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (out_valid[0] !== 1'b1 || out_data[W-1:0] !== e || ack_tog !== exp_ack) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL t2_stable: got %b want 1", stable); else n_pass++;
    out_ready[0] = 1'b1;
    tick();
    n_checks++; if (out_valid[0] !== 1'b0) $display("FAIL t2_accept: valid got %b want 0", out_valid[0]); else n_pass++;
    exp_ack[0] = ~exp_ack[0];
    tick();
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t2_ack: got %b want %b", ack_tog, exp_ack); else n_pass++;
    repeat (5) tick();
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t2_ack_once: got %b want %b", ack_tog, exp_ack); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [W-1:0] e;
    int ch;
    out_ready[1] = 1'b0;
    send(1, 32'hA5A5_0001);
    push_exp(1, 32'hA5A5_0001);
    repeat (4) tick();
    e = exp_q.pop_front(); ch = exp_ch_q.pop_front();
    n_checks++; if (out_valid[ch] !== 1'b1 || out_data[ch*W +: W] !== e)
      $display("FAIL t3_present: valid %b data %h want 1 %h", out_valid[ch], out_data[ch*W +: W], e); else n_pass++;
    send(1, 32'hA5A5_0001);
    repeat (3) tick();
    n_checks++; if (ovr_flag !== 4'b0010) $display("FAIL t3_ovr_set: got %b want 0010", ovr_flag); else n_pass++;
    out_ready[1] = 1'b1;
    tick();
    n_checks++; if (out_valid[1] !== 1'b0) $display("FAIL t3_accept: valid got %b want 0", out_valid[1]); else n_pass++;
    exp_ack[1] = ~exp_ack[1];
    repeat (8) tick();
    n_checks++; if (ack_tog !== exp_ack || out_valid !== '0)
      $display("FAIL t3_one_ack: ack %b valid %b want %b 0000", ack_tog, out_valid, exp_ack); else n_pass++;
    n_checks++; if (ovr_flag !== 4'b0010) $display("FAIL t3_ovr_sticky: got %b want 0010", ovr_flag); else n_pass++;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_checks++; if (ovr_flag !== '0) $display("FAIL t3_ovr_clr: got %b want 0000", ovr_flag); else n_pass++;
    // Clear and a fresh overrun on the same edge: the set must win.
    out_ready[2] = 1'b0;
    send(2, 32'h0000_0C02);
    push_exp(2, 32'h0000_0C02);
    repeat (4) tick();
    e = exp_q.pop_front(); ch = exp_ch_q.pop_front();
    n_checks++; if (out_valid[ch] !== 1'b1 || out_data[ch*W +: W] !== e)
      $display("FAIL t3_present2: valid %b data %h want 1 %h", out_valid[ch], out_data[ch*W +: W], e); else n_pass++;
    send(2, 32'h0000_0C02);
    repeat (2) tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_checks++; if (ovr_flag !== 4'b0100) $display("FAIL t3_set_wins: got %b want 0100", ovr_flag); else n_pass++;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    out_ready[2] = 1'b1;
    n_checks++; if (ovr_flag !== '0) $display("FAIL t3_ovr_clr2: got %b want 0000", ovr_flag); else n_pass++;
    tick();
    exp_ack[2] = ~exp_ack[2];
    tick();
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t3_ack2: got %b want %b", ack_tog, exp_ack); else n_pass++;
  endtask

  task automatic test_all_channels();
    logic [W-1:0] e;
    int ch;
    out_ready = '1;
    for (int i = 0; i < N_CH; i++) begin
      send(i, W'(i + 1));
      push_exp(i, W'(i + 1));
    end
    repeat (3) tick();
    n_checks++; if (out_valid !== '0) $display("FAIL t4_early: got %b want 0000", out_valid); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 4'hF) $display("FAIL t4_valid: got %b want 1111", out_valid); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ch = exp_ch_q.pop_front();
      n_checks++; if (out_data[ch*W +: W] !== e)
        $display("FAIL t4_data ch%0d: got %h want %h", ch, out_data[ch*W +: W], e); else n_pass++;
    end
    tick();
    n_checks++; if (out_valid !== '0) $display("FAIL t4_drop: got %b want 0000", out_valid); else n_pass++;
    exp_ack = ~exp_ack;
    tick();
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t4_ack: got %b want %b", ack_tog, exp_ack); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic spurious;
    out_ready[0] = 1'b0;
    send(0, 32'h1234_5678);
    repeat (4) tick();
    n_checks++; if (out_valid[0] !== 1'b1) $display("FAIL t5_present: valid got %b want 1", out_valid[0]); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== '0 || out_data !== '0)
      $display("FAIL t5_async: valid %b data %h want 0", out_valid, out_data); else n_pass++;
    n_checks++; if (ack_tog !== '0) $display("FAIL t5_ack: got %b want 0000", ack_tog); else n_pass++;
    req_tog = '0; data_in = '0; exp_ack = '0;
    exp_q.delete(); exp_ch_q.delete();
    #2 rst_n = 1'b1;
    out_ready = '1;
    spurious = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid !== '0 || ack_tog !== '0) spurious = 1'b1;
    end
    n_checks++; if (spurious !== 1'b0) $display("FAIL t5_spurious: got %b want 0", spurious); else n_pass++;
  endtask

`ifdef SYNC_RX_CHANGE_ONLY_EN
  task automatic test_change_only();
    logic seen;
    logic [W-1:0] e;
    int ch;
    out_ready = '1;
    seen = 1'b0;
    send(0, '0);
    repeat (6) begin tick(); if (out_valid[0] !== 1'b0) seen = 1'b1; end
    exp_ack[0] = ~exp_ack[0];
    n_checks++; if (seen !== 1'b0) $display("FAIL t6_zero_valid: got %b want 0", seen); else n_pass++;
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t6_zero_ack: got %b want %b", ack_tog, exp_ack); else n_pass++;
    send(0, 32'h55);
    push_exp(0, 32'h55);
    repeat (4) tick();
    e = exp_q.pop_front(); ch = exp_ch_q.pop_front();
    n_checks++; if (out_valid[ch] !== 1'b1 || out_data[ch*W +: W] !== e)
      $display("FAIL t6_first: valid %b data %h want 1 %h", out_valid[ch], out_data[ch*W +: W], e); else n_pass++;
    repeat (3) tick();
    exp_ack[0] = ~exp_ack[0];
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t6_first_ack: got %b want %b", ack_tog, exp_ack); else n_pass++;
    seen = 1'b0;
    send(0, 32'h55);
    repeat (6) begin tick(); if (out_valid[0] !== 1'b0) seen = 1'b1; end
    exp_ack[0] = ~exp_ack[0];
    n_checks++; if (seen !== 1'b0) $display("FAIL t6_repeat_valid: got %b want 0", seen); else n_pass++;
    n_checks++; if (ack_tog !== exp_ack) $display("FAIL t6_repeat_ack: got %b want %b", ack_tog, exp_ack); else n_pass++;
  endtask
`endif

  // Test sequence and final report.
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_all_channels();
    test_reset_mid();
`ifdef SYNC_RX_CHANGE_ONLY_EN
    test_change_only();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
